// File: rtl/seg7_paged_display.sv
// Paged seven-segment driver: alternates a time page and a date page in run
// mode, holds one page with blinking digits in edit mode.
module seg7_paged_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int PAGE_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   page0_bcd,
    input  logic [4*NUM_DIGITS-1:0]   page1_bcd,
    input  logic                      edit,
    input  logic                      edit_page,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [7*NUM_DIGITS-1:0]   hex_out,
    output logic [1:0]                page_led,
    output logic                      page_now
);

    localparam int PW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    localparam logic [6:0] POL  = ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] DARK = 7'h7F ^ POL;

    logic [PW-1:0] page_cnt;
    logic [PW-1:0] page_cnt_nxt;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nxt;
    logic          blink_on;
    logic          blink_nxt;
    logic          page_nxt;
    logic          edit_q;
    logic [1:0]    led_nxt;
    logic [7*NUM_DIGITS-1:0] hex_nxt;

    function automatic logic [6:0] seg_al(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    // Outputs are decoded from next state so page, LEDs and digits
    // all change on the same edge.
    always_comb begin
        page_cnt_nxt  = page_cnt;
        page_nxt      = page_now;
        blink_cnt_nxt = blink_cnt;
        blink_nxt     = blink_on;
        if (edit) begin
            page_cnt_nxt = '0;
            page_nxt     = edit_page;
            if (!edit_q) begin
                blink_cnt_nxt = '0;
                blink_nxt     = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt = '0;
                blink_nxt     = ~blink_on;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt_nxt = '0;
            blink_nxt     = 1'b1;
            if (edit_q) begin
                page_cnt_nxt = '0;
            end else if (page_cnt == PAGE_LAST) begin
                page_cnt_nxt = '0;
                page_nxt     = ~page_now;
            end else begin
                page_cnt_nxt = page_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        led_nxt = 2'b00;
        if (edit) begin
            led_nxt[edit_page] = blink_nxt;
        end else begin
            led_nxt[page_nxt] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic [3:0] bcd;
        logic       dark;
        assign bcd  = page_nxt ? page1_bcd[4*i +: 4]
                               : page0_bcd[4*i +: 4];
        assign dark = edit && blink_mask[i] && !blink_nxt;
        assign hex_nxt[7*i +: 7] = dark ? DARK : (seg_al(bcd) ^ POL);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            page_cnt  <= '0;
            blink_cnt <= '0;
            page_now  <= 1'b0;
            blink_on  <= 1'b1;
            edit_q    <= 1'b0;
            hex_out   <= {NUM_DIGITS{DARK}};
            page_led  <= 2'b00;
        end else begin
            page_cnt  <= page_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            page_now  <= page_nxt;
            blink_on  <= blink_nxt;
            edit_q    <= edit;
            hex_out   <= hex_nxt;
            page_led  <= led_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_paged_display.sv
// Directed bench for seg7_paged_display with 4 digits, 8-cycle pages
// and 4-cycle blink half-periods.
module tb_seg7_paged_display;

    logic        CLOCK_50;
    logic        reset;
    logic [15:0] page0_bcd;
    logic [15:0] page1_bcd;
    logic        edit;
    logic        edit_page;
    logic [3:0]  blink_mask;
    logic [27:0] hex_out;
    logic [1:0]  page_led;
    logic        page_now;

    int errors = 0;
    int checks = 0;

    localparam logic [27:0] DARK  = 28'hFFFFFFF;
    localparam logic [27:0] H1234 = {7'b1001111, 7'b0010010,
                                     7'b0000110, 7'b1001100};
    localparam logic [27:0] H2024 = {7'b0010010, 7'b0000001,
                                     7'b0010010, 7'b1001100};
    localparam logic [27:0] H2024B = {7'b0010010, 7'b0000001,
                                      7'b1111111, 7'b1111111};
    localparam logic [27:0] HA9F0 = {7'b1111110, 7'b0000100,
                                     7'b1111110, 7'b0000001};

    seg7_paged_display #(
        .NUM_DIGITS(4),
        .PAGE_CYCLES(8),
        .BLINK_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .page0_bcd(page0_bcd),
        .page1_bcd(page1_bcd),
        .edit(edit),
        .edit_page(edit_page),
        .blink_mask(blink_mask),
        .hex_out(hex_out),
        .page_led(page_led),
        .page_now(page_now)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic test_reset;
        logic [30:0] exp;
        logic [30:0] got;
        reset = 1'b1;
        page0_bcd = 16'h1234;
        page1_bcd = 16'h2024;
        edit = 1'b0;
        edit_page = 1'b0;
        blink_mask = 4'b0011;
        tick(3);
        exp = {DARK, 2'b00, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        reset = 1'b0;
        tick(1);
        exp = {H1234, 2'b01, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_run;
        logic [30:0] exp;
        logic [30:0] got;
        tick(6);
        exp = {H1234, 2'b01, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_page0_end got=%h exp=%h", got, exp);
        end
        tick(1);
        exp = {H2024, 2'b10, 1'b1};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_page1_start got=%h exp=%h", got, exp);
        end
        tick(7);
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_page1_end got=%h exp=%h", got, exp);
        end
        tick(1);
        exp = {H1234, 2'b01, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_page0_again got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_invalid_bcd;
        page0_bcd = 16'hA9F0;
        tick(1);
        checks++;
        if (hex_out !== HA9F0) begin
            errors++;
            $display("FAIL invalid_bcd got=%h exp=%h", hex_out, HA9F0);
        end
        page0_bcd = 16'h1234;
        tick(1);
        checks++;
        if (hex_out !== H1234) begin
            errors++;
            $display("FAIL bcd_restore got=%h exp=%h", hex_out, H1234);
        end
    endtask

    task automatic test_simultaneous;
        logic [30:0] exp;
        logic [30:0] got;
        tick(5);
        edit = 1'b1;
        edit_page = 1'b0;
        tick(1);
        exp = {H1234, 2'b01, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL simul_edit_wins got=%h exp=%h", got, exp);
        end
        edit = 1'b0;
        tick(1);
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL simul_exit got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_edit_blink;
        logic [30:0] exp;
        logic [30:0] got;
        edit = 1'b1;
        edit_page = 1'b1;
        blink_mask = 4'b0011;
        for (int c = 1; c <= 14; c++) begin
            tick(1);
            if (((c - 1) / 4) % 2 == 0)
                exp = {H2024, 2'b10, 1'b1};
            else
                exp = {H2024B, 2'b00, 1'b1};
            got = {hex_out, page_led, page_now};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL edit_blink c=%0d got=%h exp=%h",
                         c, got, exp);
            end
        end
    endtask

    task automatic test_edit_entry_exit;
        logic [30:0] exp;
        logic [30:0] got;
        edit = 1'b0;
        tick(1);
        exp = {H2024, 2'b10, 1'b1};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL exit_hold got=%h exp=%h", got, exp);
        end
        edit = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick(1);
            exp = (c <= 4) ? {H2024, 2'b10, 1'b1}
                           : {H2024B, 2'b00, 1'b1};
            got = {hex_out, page_led, page_now};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL entry_visible c=%0d got=%h exp=%h",
                         c, got, exp);
            end
        end
        edit = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            exp = (c <= 8) ? {H2024, 2'b10, 1'b1}
                           : {H1234, 2'b01, 1'b0};
            got = {hex_out, page_led, page_now};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL exit_dwell c=%0d got=%h exp=%h",
                         c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [30:0] exp;
        logic [30:0] got;
        tick(3);
        reset = 1'b1;
        #1;
        exp = {DARK, 2'b00, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", got, exp);
        end
        tick(2);
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", got, exp);
        end
        reset = 1'b0;
        tick(1);
        exp = {H1234, 2'b01, 1'b0};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_release got=%h exp=%h", got, exp);
        end
        tick(7);
        exp = {H2024, 2'b10, 1'b1};
        got = {hex_out, page_led, page_now};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_dwell got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_invalid_bcd();
        test_simultaneous();
        test_edit_blink();
        test_edit_entry_exit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
